// File: rtl/matrix_wb_sequencer.sv
// matrix_wb_sequencer: drains a packed matrix-multiply result vector into the
// register file one element per cycle, arbitrating the register-file write port
// against the normal MEM/WB write-back and tracking registers still awaiting a
// matrix write so the hazard unit can stall dependent reads.
//
// Ports:
//   CLK, reset                       clock, synchronous active-high reset
//   res_valid/res_ready              result-vector capture handshake
//   res_data, res_base               packed elements and destination of element 0
//   pipe_write/destreg/wrtdata       normal MEM/WB write-back request
//   write_out/destreg_out/wrtdata_out register-file write port (combinational)
//   wb_stall                         MEM/WB write was not performed this cycle
//   rd_addr1/rd_addr2, rd_pending    decode-stage hazard query (combinational)
//   busy                             drain in progress
//   done                             registered pulse after the last element commits
module matrix_wb_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ELEMS       = 4,
  parameter int unsigned AW          = 3,
  parameter int unsigned PRIO_MATRIX = 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [DATA_W*ELEMS-1:0] res_data,
  input  logic [AW-1:0]           res_base,
  input  logic                    pipe_write,
  input  logic [AW-1:0]           pipe_destreg,
  input  logic [DATA_W-1:0]       pipe_wrtdata,
  output logic                    write_out,
  output logic [AW-1:0]           destreg_out,
  output logic [DATA_W-1:0]       wrtdata_out,
  output logic                    wb_stall,
  input  logic [AW-1:0]           rd_addr1,
  input  logic [AW-1:0]           rd_addr2,
  output logic                    rd_pending,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned IW   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned VW   = DATA_W * ELEMS;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [VW-1:0]     data_q;
  logic [AW-1:0]     base_q;
  logic [AW-1:0]     elem_addr;
  logic [DATA_W-1:0] elem_data;
  logic [NREG-1:0]   pending_q, pending_d, set_mask, clr_mask;
  logic              capture, commit, last;

  // Current element and its wrapped destination register
  assign elem_addr = base_q + AW'(idx_q);
  assign elem_data = DATA_W'(data_q >> (32'(idx_q) * DATA_W));
  assign last      = (idx_q == IW'(ELEMS - 1));

  assign res_ready  = (state_q == IDLE);
  assign busy       = (state_q == DRAIN);
  assign capture    = res_ready && res_valid;
  assign rd_pending = pending_q[rd_addr1] | pending_q[rd_addr2];

  // Registers claimed by a newly captured vector
  always_comb begin
    set_mask = '0;
    for (int unsigned k = 0; k < ELEMS; k++) begin
      set_mask[res_base + AW'(k)] = 1'b1;
    end
  end

  // A pending bit stays set through its write cycle and clears on the commit edge
  assign clr_mask  = commit ? (NREG'(1) << elem_addr) : '0;
  assign pending_d = (pending_q & ~clr_mask) | (capture ? set_mask : '0);

  // Next state and write-port arbitration
  always_comb begin
    state_d     = state_q;
    write_out   = pipe_write;
    destreg_out = pipe_destreg;
    wrtdata_out = pipe_wrtdata;
    wb_stall    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if ((PRIO_MATRIX != 0) || !pipe_write) begin
          write_out   = 1'b1;
          destreg_out = elem_addr;
          wrtdata_out = elem_data;
          wb_stall    = (PRIO_MATRIX != 0) && pipe_write;
          commit      = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, vector capture, element index, pending set and completion pulse
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      base_q    <= '0;
      pending_q <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done      <= commit && last;
      if (capture) begin
        data_q <= res_data;
        base_q <= res_base;
        idx_q  <= '0;
      end else if (commit) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_wb_sequencer.sv
// Bench for matrix_wb_sequencer: one PRIO_MATRIX=1 instance, one PRIO_MATRIX=0
// instance and one ELEMS=1 instance share the stimulus; each scenario checks
// one instance against a per-cycle reference built from the element counter.
module tb_matrix_wb_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned EL = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 1 << AW;

  typedef struct packed {
    logic          ready;
    logic          wr;
    logic [AW-1:0] dst;
    logic [DW-1:0] wd;
    logic          stall;
    logic          pend;
    logic          busy;
    logic          done;
  } obs_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             reset, res_valid, pipe_write;
  logic [DW*EL-1:0] res_data;
  logic [AW-1:0]    res_base, pipe_destreg, rd_addr1, rd_addr2;
  logic [DW-1:0]    pipe_wrtdata;

  logic m1_ready, m1_wr, m1_stall, m1_pend, m1_busy, m1_done;
  logic m0_ready, m0_wr, m0_stall, m0_pend, m0_busy, m0_done;
  logic e1_ready, e1_wr, e1_stall, e1_pend, e1_busy, e1_done;
  logic [AW-1:0] m1_dst, m0_dst, e1_dst;
  logic [DW-1:0] m1_wd, m0_wd, e1_wd;
  obs_t o1, o0, oe;

  int checks = 0;
  int errors = 0;

  matrix_wb_sequencer #(.DATA_W(DW), .ELEMS(EL), .AW(AW), .PRIO_MATRIX(1)) dut_m1 (
    .CLK(CLK), .reset(reset), .res_valid(res_valid), .res_ready(m1_ready),
    .res_data(res_data), .res_base(res_base), .pipe_write(pipe_write),
    .pipe_destreg(pipe_destreg), .pipe_wrtdata(pipe_wrtdata), .write_out(m1_wr),
    .destreg_out(m1_dst), .wrtdata_out(m1_wd), .wb_stall(m1_stall),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_pending(m1_pend),
    .busy(m1_busy), .done(m1_done));

  matrix_wb_sequencer #(.DATA_W(DW), .ELEMS(EL), .AW(AW), .PRIO_MATRIX(0)) dut_m0 (
    .CLK(CLK), .reset(reset), .res_valid(res_valid), .res_ready(m0_ready),
    .res_data(res_data), .res_base(res_base), .pipe_write(pipe_write),
    .pipe_destreg(pipe_destreg), .pipe_wrtdata(pipe_wrtdata), .write_out(m0_wr),
    .destreg_out(m0_dst), .wrtdata_out(m0_wd), .wb_stall(m0_stall),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_pending(m0_pend),
    .busy(m0_busy), .done(m0_done));

  matrix_wb_sequencer #(.DATA_W(DW), .ELEMS(1), .AW(AW), .PRIO_MATRIX(1)) dut_e1 (
    .CLK(CLK), .reset(reset), .res_valid(res_valid), .res_ready(e1_ready),
    .res_data(res_data[DW-1:0]), .res_base(res_base), .pipe_write(pipe_write),
    .pipe_destreg(pipe_destreg), .pipe_wrtdata(pipe_wrtdata), .write_out(e1_wr),
    .destreg_out(e1_dst), .wrtdata_out(e1_wd), .wb_stall(e1_stall),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_pending(e1_pend),
    .busy(e1_busy), .done(e1_done));

  assign o1 = {m1_ready, m1_wr, m1_dst, m1_wd, m1_stall, m1_pend, m1_busy, m1_done};
  assign o0 = {m0_ready, m0_wr, m0_dst, m0_wd, m0_stall, m0_pend, m0_busy, m0_done};
  assign oe = {e1_ready, e1_wr, e1_dst, e1_wd, e1_stall, e1_pend, e1_busy, e1_done};

  function automatic obs_t pick(input int sel);
    case (sel)
      0:       return o0;
      1:       return o1;
      default: return oe;
    endcase
  endfunction

  // Idle behaviour: pure pass-through, nothing pending
  function automatic obs_t idle_exp(input bit done_v);
    obs_t e;
    e       = '0;
    e.ready = 1'b1;
    e.wr    = pipe_write;
    e.dst   = pipe_destreg;
    e.wd    = pipe_wrtdata;
    e.done  = done_v;
    return e;
  endfunction

  // Register addr still awaits a write once k of n elements have been committed
  function automatic bit exp_pend(input int base, input int k, input int n, input int addr);
    for (int j = k; j < n; j++) begin
      if (((base + j) % NR) == addr) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    res_valid  = 1'b1;
    res_data   = DW*EL'($urandom);
    res_base   = AW'($urandom);
    pipe_write = 1'b0;
    step();
    step();
    reset     = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic capture(input logic [31:0] data, input int base);
    res_valid  = 1'b1;
    res_data   = data;
    res_base   = AW'(base);
    pipe_write = 1'b0;
    step();
    res_valid = 1'b0;
  endtask

  // Called in the first cycle after a capture edge; follows the drain to its done cycle
  task automatic drain_check(input string name, input int sel, input bit prio, input int n,
                             input logic [31:0] data, input int base, input logic [63:0] pat,
                             input int rd1, input int pdst, input int pdat, input int exp_done,
                             input bit chain, input logic [31:0] ndata, input int nbase,
                             input bit junk_valid);
    int   k;
    bit   finished;
    obs_t e, o;
    k        = 0;
    finished = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      pipe_write   = pat[c];
      pipe_destreg = (pdst < 0) ? AW'($urandom) : AW'(pdst);
      pipe_wrtdata = (pdat < 0) ? DW'($urandom) : DW'(pdat);
      rd_addr1     = (rd1 < 0) ? AW'($urandom) : AW'(rd1);
      rd_addr2     = AW'($urandom);
      if (k < n) begin
        res_valid = junk_valid ? 1'($urandom) : 1'b0;
        res_data  = DW*EL'($urandom);
      end else begin
        res_valid = chain;
        res_data  = ndata;
        res_base  = AW'(nbase);
      end
      @(negedge CLK);
      if (k < n) begin
        e      = '0;
        e.busy = 1'b1;
        e.pend = exp_pend(base, k, n, int'(rd_addr1)) | exp_pend(base, k, n, int'(rd_addr2));
        if (prio || !pipe_write) begin
          e.wr    = 1'b1;
          e.dst   = AW'((base + k) % NR);
          e.wd    = data[k*DW +: DW];
          e.stall = prio && pipe_write;
        end else begin
          e.wr  = 1'b1;
          e.dst = pipe_destreg;
          e.wd  = pipe_wrtdata;
        end
      end else begin
        e = idle_exp(1'b1);
      end
      o = pick(sel);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, o, e);
      end
      if (k >= n) begin
        finished = 1'b1;
        if (exp_done >= 0) begin
          checks++;
          if (c != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, c, exp_done);
          end
        end
      end else if (prio || !pipe_write) begin
        k++;
      end
      step();
    end
    res_valid  = 1'b0;
    pipe_write = 1'b0;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: got no done expected done within 40 cycles", name);
    end else if (!chain) begin
      @(negedge CLK);
      e = idle_exp(1'b0);
      o = pick(sel);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s after_done: got %h expected %h", name, o, e);
      end
      step();
    end
  endtask

  task automatic test_reset();
    obs_t e, o;
    do_reset();
    for (int a = 0; a < int'(NR); a++) begin
      pipe_write   = 1'($urandom);
      pipe_destreg = AW'($urandom);
      pipe_wrtdata = DW'($urandom);
      rd_addr1     = AW'(a);
      rd_addr2     = AW'(a);
      @(negedge CLK);
      e = idle_exp(1'b0);
      for (int s = 0; s < 3; s++) begin
        o = pick(s);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL reset dut%0d addr%0d: got %h expected %h", s, a, o, e);
        end
      end
      step();
    end
  endtask

  task automatic test_basic();
    do_reset();
    capture(32'h04030201, 2);
    drain_check("basic_base2", 1, 1'b1, EL, 32'h04030201, 2, 64'h0, 3, -1, -1, 4, 1'b0, 0, 0, 1'b0);
    do_reset();
    capture(32'hDDCCBBAA, 6);
    drain_check("wrap_base6", 1, 1'b1, EL, 32'hDDCCBBAA, 6, 64'h0, 0, -1, -1, 4, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_contention();
    do_reset();
    capture(32'h44332211, 2);
    drain_check("prio1_contend", 1, 1'b1, EL, 32'h44332211, 2, 64'h1E, 5, 5, 8'hAA, 4,
                1'b0, 0, 0, 1'b0);
    do_reset();
    capture(32'h44332211, 2);
    drain_check("prio0_contend", 0, 1'b0, EL, 32'h44332211, 2, 64'h02, 5, 5, 8'hAA, 5,
                1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_elems1();
    do_reset();
    capture(32'h000000E7, 7);
    drain_check("elems1", 2, 1'b1, 1, 32'h000000E7, 7, 64'h1, -1, -1, -1, 1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int          ba, bb;
    a  = $urandom;
    b  = $urandom;
    ba = int'($urandom_range(0, NR - 1));
    bb = int'($urandom_range(0, NR - 1));
    do_reset();
    capture(a, ba);
    drain_check("b2b_first", 1, 1'b1, EL, a, ba, 64'h0, -1, -1, -1, 4, 1'b1, b, bb, 1'b1);
    drain_check("b2b_second", 1, 1'b1, EL, b, bb, 64'h0, -1, -1, -1, 4, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    do_reset();
    capture(32'h0A0B0C0D, 4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 0; a < int'(NR); a++) begin
      pipe_write   = 1'($urandom);
      pipe_destreg = AW'($urandom);
      pipe_wrtdata = DW'($urandom);
      rd_addr1     = AW'(a);
      rd_addr2     = AW'(a);
      @(negedge CLK);
      e = idle_exp(1'b0);
      o = pick(1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid addr%0d: got %h expected %h", a, o, e);
      end
      step();
    end
    pipe_write = 1'b0;
    capture(32'h5A6B7C8D, 1);
    drain_check("after_reset_mid", 1, 1'b1, EL, 32'h5A6B7C8D, 1, 64'h0, -1, -1, -1, 4,
                1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [63:0] pat;
    int          sel, base;
    for (int it = 0; it < 12; it++) begin
      sel  = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, NR - 1));
      d    = $urandom;
      pat  = {$urandom, $urandom} & {$urandom, $urandom} & 64'hFFF;
      do_reset();
      capture(d, base);
      drain_check($sformatf("random%0d", it), sel, sel[0], EL, d, base, pat, -1, -1, -1, -1,
                  1'b0, 0, 0, 1'b1);
    end
  endtask

  initial begin
    reset        = 1'b1;
    res_valid    = 1'b0;
    res_data     = '0;
    res_base     = '0;
    pipe_write   = 1'b0;
    pipe_destreg = '0;
    pipe_wrtdata = '0;
    rd_addr1     = '0;
    rd_addr2     = '0;
    test_reset();
    test_basic();
    test_contention();
    test_elems1();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_wb_sequencer.md
# matrix_wb_sequencer

Parametrised write-back sequencer that drains a packed matrix-multiply result vector into the register file one element per cycle. It arbitrates the register-file write port against the normal MEM/WB write-back and tracks which destination registers still await a matrix write, so the hazard unit can stall dependent reads. It generalises the fixed 4x8-bit matrix write-back path to any element count and width. It adds a selectable arbitration priority, a ready/valid capture handshake, pending-register tracking and a completion pulse. It sits between the matrix multiplier, the MEM/WB register and the register file.

## Interface
Parameters:
- DATA_W, 8, element width in bits
- ELEMS, 4, elements per result vector; legal range 1..2**AW
- AW, 3, register address width
- PRIO_MATRIX, 1, arbitration mode: 1 = matrix element wins and the pipeline is stalled; 0 = pipeline wins and the matrix waits

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- res_valid  in  1  result vector valid from the multiplier
- res_ready  out  1  sequencer can capture a vector
- res_data  in  DATA_W*ELEMS  element i at [i*DATA_W +: DATA_W]
- res_base  in  AW  destination register of element 0
- pipe_write  in  1  normal write-back enable
- pipe_destreg  in  AW  normal write-back register
- pipe_wrtdata  in  DATA_W  normal write-back data
- write_out  out  1  register-file write enable
- destreg_out  out  AW  register-file write address
- wrtdata_out  out  DATA_W  register-file write data
- wb_stall  out  1  hold the MEM/WB stage; its write was not performed
- rd_addr1, rd_addr2  in  AW each  decode-stage source registers
- rd_pending  out  1  a source register awaits a matrix write
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after the last element is committed

## Operation
- States are IDLE and DRAIN. res_ready = (state==IDLE). busy = (state==DRAIN).
- Capture happens when res_valid && res_ready at an edge:
  - latch res_data and res_base;
  - idx <= 0;
  - set pending bits for registers (res_base+k) mod 2**AW, k = 0..ELEMS-1;
  - go to DRAIN.
- In DRAIN the sequencer presents element idx to register (base+idx) mod 2**AW. Register addresses wrap modulo 2**AW.
- PRIO_MATRIX=1:
  - write_out=1, destreg_out/wrtdata_out come from the matrix element.
  - wb_stall = pipe_write.
  - idx advances every cycle.
- PRIO_MATRIX=0:
  - If pipe_write=1, the pipe fields pass through and idx holds. wb_stall=0.
  - Otherwise the matrix element is written and idx advances.
- Committing an element clears its pending bit at that edge. The bit stays set during the write cycle, which is conservative.
- On the edge that commits element ELEMS-1: go to IDLE and set done=1 for the next cycle.
- In IDLE the outputs are pure pass-through of the pipe fields. wb_stall=0.
- rd_pending = pending[rd_addr1] | pending[rd_addr2]. It is combinational.
- A pipe write to a pending register while PRIO_MATRIX=0 is performed. The later matrix write overwrites it.

## Timing
- Reset values:
  - state IDLE, idx 0, pending all 0, done 0, busy 0, res_ready 1, wb_stall 0;
  - write_out/destreg_out/wrtdata_out equal the pipe inputs.
- Latency with PRIO_MATRIX=1 or no contention:
  - capture at edge T;
  - element k written in cycle T+1+k;
  - done high in cycle T+ELEMS+1.
- Each contended cycle with PRIO_MATRIX=0 adds one cycle.
- Back-to-back: res_ready is 1 in the done cycle, so a new capture on that edge is legal. The new drain starts the next cycle.
- res_valid while busy is ignored. The producer must hold it until res_ready.
- ELEMS=1: one write cycle, then done.
- Reset asserted mid-drain: at that edge go to IDLE, clear pending and idx, and drop done. The partially written registers keep their values.
- Reset has priority over capture in the same cycle.

## Test plan
- Reset, then capture res_data=0x04030201 with base=2 (PRIO=1, no pipe traffic):
  - writes r2=01, r3=02, r4=03, r5=04 in 4 consecutive cycles;
  - done pulses one cycle later; busy is low after.
- Base=6 with ELEMS=4:
  - destinations wrap to r6, r7, r0, r1;
  - pending bits clear in that order; rd_pending for r0 drops after the third write.
- PRIO_MATRIX=1 with pipe_write=1 (r5 <= AA) during cycle 2 of the drain:
  - wb_stall=1 that cycle and the matrix element is written;
  - the held pipe write commits after the drain.
- PRIO_MATRIX=0 with the same contention:
  - the pipe write r5=AA commits and the matrix stalls one cycle;
  - done arrives at T+6 instead of T+5.
- rd_addr1=r3 during the drain of base=2:
  - rd_pending=1 until the edge committing r3, then 0.
- Reset asserted in cycle 2 of a drain:
  - the next cycle shows IDLE, pending=0, done never pulses, res_ready=1;
  - a fresh capture then completes normally.
